// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI initiator.
//   spi_state_t : frame sequencer states
//   OP_*        : command opcodes carried in cmd_data[9:8]
//   CMD_W       : command word width (opcode + payload)
//   DATA_W      : read-response width
//   CNT_W       : width of the shared bit/latency down-counter
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int CMD_W  = 10;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      CMD,
      SHIFT,
      END,
      RD_WAIT,
      RD_SHIFT,
      GAP
   } spi_state_t;

endpackage

// File: rtl/spi_shreg.sv
// ---------------------------------------------------------------------------
// spi_shreg
// Loadable shift register plus 4-bit down-counter, shared by the transmit
// and receive phases of a frame. Shifts left: the MSB leaves on ser_out and
// ser_in enters at the LSB, so one register serves both directions.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture load_data (has priority over shift_en)
//   shift_en   : shift one position towards the MSB, ser_in enters bit 0
//   ser_in     : serial input bit
//   cnt_ld     : load cnt_val into the counter (priority over cnt_dec)
//   cnt_dec    : decrement the counter, saturating at zero
//   ser_out    : current MSB
//   rx_byte    : low byte as it will be after the next shift, so a receive
//                phase can hand over the complete byte on its last edge
//   cnt_zero   : counter has reached its terminal count
// ---------------------------------------------------------------------------
module spi_shreg
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [CMD_W-1:0]  load_data,
   input  logic              shift_en,
   input  logic              ser_in,
   input  logic              cnt_ld,
   input  logic [CNT_W-1:0]  cnt_val,
   input  logic              cnt_dec,
   output logic              ser_out,
   output logic [DATA_W-1:0] rx_byte,
   output logic              cnt_zero
);

   logic [CMD_W-1:0] sh_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else if (load) begin
         sh_q <= load_data;
      end else if (shift_en) begin
         sh_q <= {sh_q[CMD_W-2:0], ser_in};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_ld) begin
         cnt_q <= cnt_val;
      end else if (cnt_dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign ser_out  = sh_q[CMD_W-1];
   assign rx_byte  = {sh_q[DATA_W-2:0], ser_in};
   assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// Host-side SPI initiator. Accepts a 10-bit command on a valid/ready
// handshake, sends it MSB-first on MOSI under SS_n (one bit per clk), and for
// rd-data commands collects an 8-bit response from MISO.
//
// Parameters:
//   RD_LAT  : idle cycles between last MOSI bit and first MISO sample (1..15)
//   GAP_CYC : cycles SS_n stays high after a frame before IDLE (>= 1)
//
// Ports:
//   clk        in   system clock, also the serial bit clock
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  idle, command will be accepted (combinational: state==IDLE)
//   cmd_data   in   [9:8] opcode, [7:0] payload
//   rd_data    out  last byte returned by a rd-data frame
//   rd_valid   out  one-cycle pulse when rd_data updates
//   busy       out  frame or gap in progress
//   proto_err  out  one-cycle pulse on a rejected rd-data command
//   SS_n       out  slave select, active low
//   MOSI       out  serial data to slave, 0 whenever SS_n is high
//   MISO       in   serial data from slave
//
// Build option: define SPI_MASTER_RD_SEQ_CHK_EN to reject a rd-data command
// that is not preceded by a completed rd-addr frame. Without it proto_err is
// constant 0 and every opcode is forwarded.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// START    | SS_n low, MOSI 0
// CMD      | select bit (cmd[9]) on MOSI
// SHIFT    | cmd[9:0] on MOSI, counter 9..0
// END      | write / rd-addr trailer, SS_n still low
// RD_WAIT  | turnaround before the response, counter RD_LAT-1..0
// RD_SHIFT | MISO sampled each cycle, counter 7..0
// GAP      | SS_n high, busy, counter GAP_CYC-1..0
// ---------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter int RD_LAT  = 2,
   parameter int GAP_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CMD_W-1:0]  cmd_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              proto_err,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int               GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_TX    = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] CNT_RX    = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(RD_LAT - 1);

   spi_state_t        state;
   spi_state_t        state_nxt;
   logic [1:0]        op;
   logic [GAP_W-1:0]  gap_cnt;
   logic [GAP_W-1:0]  gap_val;
   logic              gap_ld;
   logic              gap_zero;

   logic              ss_n_nxt;
   logic              mosi_nxt;
   logic              err_nxt;
   logic              rd_cap;
   logic              op_ld;

   logic              sh_load;
   logic              sh_shift;
   logic              cnt_ld;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_dec;
   logic              sh_msb;
   logic [DATA_W-1:0] rx_byte;
   logic              cnt_zero;

   logic              rd_seq_bad;

   spi_shreg u_shreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .load_data (cmd_data),
      .shift_en  (sh_shift),
      .ser_in    (MISO),
      .cnt_ld    (cnt_ld),
      .cnt_val   (cnt_val),
      .cnt_dec   (cnt_dec),
      .ser_out   (sh_msb),
      .rx_byte   (rx_byte),
      .cnt_zero  (cnt_zero)
   );

`ifdef SPI_MASTER_RD_SEQ_CHK_EN
   logic rd_addr_seen;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_seen <= 1'b0;
      end else if (rd_cap) begin
         rd_addr_seen <= 1'b0;
      end else if ((state == END) && (op == OP_RD_ADDR)) begin
         rd_addr_seen <= 1'b1;
      end
   end

   assign rd_seq_bad = (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA) && !rd_addr_seen;
`else
   assign rd_seq_bad = 1'b0;
`endif

   assign cmd_ready = (state == IDLE);
   assign gap_zero  = (gap_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ss_n_nxt  = 1'b1;
      mosi_nxt  = 1'b0;
      err_nxt   = 1'b0;
      rd_cap    = 1'b0;
      op_ld     = 1'b0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      cnt_ld    = 1'b0;
      cnt_val   = CNT_TX;
      cnt_dec   = 1'b0;
      gap_ld    = 1'b0;
      gap_val   = GAP_LOAD;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               op_ld   = 1'b1;
               sh_load = 1'b1;
               if (rd_seq_bad) begin
                  // Rejected rd-data: one busy cycle with SS_n high, no frame.
                  state_nxt = GAP;
                  gap_ld    = 1'b1;
                  gap_val   = '0;
                  err_nxt   = 1'b1;
               end else begin
                  state_nxt = START;
                  ss_n_nxt  = 1'b0;
               end
            end
         end

         START: begin
            state_nxt = CMD;
            ss_n_nxt  = 1'b0;
            mosi_nxt  = sh_msb;
         end

         CMD: begin
            // cmd[9] is sent twice: once as the select bit, once as the
            // first data bit, so it is presented again before shifting.
            state_nxt = SHIFT;
            ss_n_nxt  = 1'b0;
            mosi_nxt  = sh_msb;
            sh_shift  = 1'b1;
            cnt_ld    = 1'b1;
            cnt_val   = CNT_TX;
         end

         SHIFT: begin
            ss_n_nxt = 1'b0;
            if (cnt_zero) begin
               if (op == OP_RD_DATA) begin
                  state_nxt = RD_WAIT;
                  cnt_ld    = 1'b1;
                  cnt_val   = CNT_WAIT;
               end else begin
                  state_nxt = END;
               end
            end else begin
               mosi_nxt = sh_msb;
               sh_shift = 1'b1;
               cnt_dec  = 1'b1;
            end
         end

         END: begin
            state_nxt = GAP;
            gap_ld    = 1'b1;
         end

         RD_WAIT: begin
            ss_n_nxt = 1'b0;
            if (cnt_zero) begin
               state_nxt = RD_SHIFT;
               cnt_ld    = 1'b1;
               cnt_val   = CNT_RX;
            end else begin
               cnt_dec = 1'b1;
            end
         end

         RD_SHIFT: begin
            sh_shift = 1'b1;
            if (cnt_zero) begin
               // Last sample goes straight into rd_data via rx_byte.
               state_nxt = GAP;
               gap_ld    = 1'b1;
               rd_cap    = 1'b1;
            end else begin
               ss_n_nxt = 1'b0;
               cnt_dec  = 1'b1;
            end
         end

         GAP: begin
            if (gap_zero) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         proto_err <= 1'b0;
         op        <= OP_WR_ADDR;
         gap_cnt   <= '0;
      end else begin
         SS_n      <= ss_n_nxt;
         MOSI      <= mosi_nxt;
         rd_valid  <= rd_cap;
         busy      <= (state_nxt != IDLE);
         proto_err <= err_nxt;
         if (rd_cap) begin
            rd_data <= rx_byte;
         end
         if (op_ld) begin
            op <= cmd_data[CMD_W-1 -: 2];
         end
         if (gap_ld) begin
            gap_cnt <= gap_val;
         end else if (!gap_zero) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
// Directed plus randomized frames. Expected pin activity is derived from the
// frame timeline (cycle number after the accept edge), a small slave model
// rebuilds the MOSI word and supplies MISO responses.
// ---------------------------------------------------------------------------
module tb_spi_master;

   localparam int RD_LAT  = 2;
   localparam int GAP_CYC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_data = '0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       proto_err;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b0;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_rd = '0;
   bit         rd_addr_seen = 1'b0;

   always #5 clk = ~clk;

   spi_master #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .proto_err (proto_err),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ss_n"},   32'(SS_n),      32'd1);
      check({tag, " mosi"},   32'(MOSI),      32'd0);
      check({tag, " busy"},   32'(busy),      32'd0);
      check({tag, " ready"},  32'(cmd_ready), 32'd1);
      check({tag, " rd_vld"}, 32'(rd_valid),  32'd0);
      check({tag, " p_err"},  32'(proto_err), 32'd0);
      check({tag, " rd_dat"}, 32'(rd_data),   32'(last_rd));
   endtask

   // Entered at a negedge with the DUT idle. Presents cmd, then walks the
   // frame cycle by cycle. Returns at the negedge of the first idle cycle
   // (or of cycle abort_at, with rst_n driven low).
   task automatic frame(input logic [9:0] cmd, input logic [7:0] resp,
                        input bit keep_valid, input int abort_at);
      bit         is_rd;
      bit         blocked;
      bit         stop;
      int         fend;
      int         last;
      logic [9:0] rx;
      logic       e_ss, e_mosi, e_busy, e_rdy, e_rv, e_err;

      is_rd   = (cmd[9:8] == 2'b11);
      blocked = 1'b0;
`ifdef SPI_MASTER_RD_SEQ_CHK_EN
      blocked = is_rd && !rd_addr_seen;
`endif
      fend = is_rd ? 20 + RD_LAT : 13;
      last = blocked ? 2 : fend + GAP_CYC + 1;
      rx   = '0;
      stop = 1'b0;

      cmd_valid = 1'b1;
      cmd_data  = cmd;
      check($sformatf("cmd %03h accept ready", cmd), 32'(cmd_ready), 32'd1);

      for (int c = 1; c <= last && !stop; c++) begin
         @(negedge clk);
         cmd_valid = keep_valid;
         cmd_data  = 10'($urandom);
         if (is_rd && !blocked && c >= 13 + RD_LAT && c <= 20 + RD_LAT)
            MISO = resp[7 - (c - 13 - RD_LAT)];
         else
            MISO = 1'($urandom);

         if (blocked) begin
            e_ss   = 1'b1;
            e_mosi = 1'b0;
            e_busy = (c == 1);
            e_rdy  = (c == 2);
            e_rv   = 1'b0;
            e_err  = (c == 1);
         end else begin
            e_ss   = (c > fend);
            e_busy = (c <= fend + GAP_CYC);
            e_rdy  = (c == last);
            e_rv   = is_rd && (c == fend + 1);
            e_err  = 1'b0;
            if (c == 2)
               e_mosi = cmd[9];
            else if (c >= 3 && c <= 12)
               e_mosi = cmd[12 - c];
            else
               e_mosi = 1'b0;
         end
         if (e_rv) last_rd = resp;

         check($sformatf("cmd %03h c%0d ss_n",   cmd, c), 32'(SS_n),      32'(e_ss));
         check($sformatf("cmd %03h c%0d mosi",   cmd, c), 32'(MOSI),      32'(e_mosi));
         check($sformatf("cmd %03h c%0d busy",   cmd, c), 32'(busy),      32'(e_busy));
         check($sformatf("cmd %03h c%0d ready",  cmd, c), 32'(cmd_ready), 32'(e_rdy));
         check($sformatf("cmd %03h c%0d rd_vld", cmd, c), 32'(rd_valid),  32'(e_rv));
         check($sformatf("cmd %03h c%0d rd_dat", cmd, c), 32'(rd_data),   32'(last_rd));
         check($sformatf("cmd %03h c%0d p_err",  cmd, c), 32'(proto_err), 32'(e_err));

         // Slave model: collect the ten data bits while selected.
         if (!SS_n && c >= 3 && c <= 12) rx = {rx[8:0], MOSI};
         if (!blocked && c == 13)
            check($sformatf("cmd %03h slave rx", cmd), 32'(rx), 32'(cmd));

         if (c == abort_at) begin
            rst_n     = 1'b0;
            cmd_valid = 1'b0;
            stop      = 1'b1;
         end
      end

      if (stop) begin
         rd_addr_seen = 1'b0;
         last_rd      = '0;
      end else if (!blocked) begin
         if (cmd[9:8] == 2'b10) rd_addr_seen = 1'b1;
         if (is_rd)             rd_addr_seen = 1'b0;
      end
   endtask

   initial begin
      logic [9:0] rcmd;
      bit         kv;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      // Write address 0xA5.
      frame(10'h0A5, 8'h00, 1'b0, 0);

      // Back-to-back with cmd_valid held through the first frame.
      frame(10'h1FF, 8'h00, 1'b1, 0);
      frame(10'h100, 8'h00, 1'b0, 0);

      // Read address then read data returning 0x5A.
      frame(10'h2C3, 8'h00, 1'b0, 0);
      frame(10'h300, 8'h5A, 1'b0, 0);

      // Reset during cycle 7 of a write frame.
      frame(10'h0C3, 8'h00, 1'b0, 7);
      @(negedge clk);
      check_idle("mid-frame reset");
      rst_n = 1'b1;

      // Rd-data straight after reset (rejected only with the sequence check).
      frame(10'h300, 8'hC3, 1'b0, 0);
      frame(10'h012, 8'h00, 1'b0, 0);

      for (int i = 0; i < 24; i++) begin
         rcmd = 10'($urandom);
         kv   = (i < 23) ? 1'($urandom) : 1'b0;
         frame(rcmd, 8'($urandom), kv, 0);
      end

      cmd_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_idle("final idle");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
